// File: rtl/riscv_idex_operand_pkg.sv
// Shared constants and types for the ID/EX operand stage: datapath width, ALU codes,
// forward-select codes and the EX pipeline register layout.
package riscv_idex_operand_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
    localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
    localparam logic [3:0] ALU_CTRL_SLL  = 4'd2;
    localparam logic [3:0] ALU_CTRL_SLT  = 4'd3;
    localparam logic [3:0] ALU_CTRL_SLTU = 4'd4;
    localparam logic [3:0] ALU_CTRL_XOR  = 4'd5;
    localparam logic [3:0] ALU_CTRL_SRL  = 4'd6;
    localparam logic [3:0] ALU_CTRL_SRA  = 4'd7;
    localparam logic [3:0] ALU_CTRL_OR   = 4'd8;
    localparam logic [3:0] ALU_CTRL_AND  = 4'd9;

    localparam logic [1:0] FWD_SEL_REG = 2'd0;
    localparam logic [1:0] FWD_SEL_MEM = 2'd1;
    localparam logic [1:0] FWD_SEL_WB  = 2'd2;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [3:0]      alu_ctrl;
        logic            zero_condition;
        logic            src_a_sel;
        logic            src_b_sel;
        logic            reg_wr_en;
        logic            mem_wr_en;
        logic            mem_rd_en;
    } idex_reg_t;

    // A bubble has zero rs addresses, so it can never pick up a forwarded value.
    localparam idex_reg_t EX_BUBBLE = '{
        valid:          1'b0,
        pc:             '0,
        rs1_data:       '0,
        rs2_data:       '0,
        imm:            '0,
        rs1_addr:       5'd0,
        rs2_addr:       5'd0,
        rd_addr:        5'd0,
        alu_ctrl:       ALU_CTRL_ADD,
        zero_condition: 1'b0,
        src_a_sel:      1'b0,
        src_b_sel:      1'b0,
        reg_wr_en:      1'b0,
        mem_wr_en:      1'b0,
        mem_rd_en:      1'b0
    };

endpackage

// File: rtl/riscv_idex_operand_if.sv
// Decode, MEM/WB producer and EX operand signals of the ID/EX stage.
// The master side drives decode/producer fields; the slave side is the ID/EX block.
interface riscv_idex_operand_if;
    import riscv_idex_operand_pkg::*;

    logic            i_stall;
    logic            i_flush;
    logic            i_id_valid;
    logic [XLEN-1:0] i_id_pc;
    logic [XLEN-1:0] i_id_rs1_data;
    logic [XLEN-1:0] i_id_rs2_data;
    logic [XLEN-1:0] i_id_imm;
    logic [4:0]      i_id_rs1_addr;
    logic [4:0]      i_id_rs2_addr;
    logic [4:0]      i_id_rd_addr;
    logic [3:0]      i_id_alu_ctrl;
    logic            i_id_zero_condition;
    logic            i_id_src_a_sel;
    logic            i_id_src_b_sel;
    logic            i_id_reg_wr_en;
    logic            i_id_mem_wr_en;
    logic            i_id_mem_rd_en;
    logic [4:0]      i_mem_rd_addr;
    logic            i_mem_reg_wr_en;
    logic [XLEN-1:0] i_mem_fwd_data;
    logic [4:0]      i_wb_rd_addr;
    logic            i_wb_reg_wr_en;
    logic [XLEN-1:0] i_wb_data;

    logic [XLEN-1:0] o_alu_a;
    logic [XLEN-1:0] o_alu_b;
    logic [3:0]      o_alu_ctrl;
    logic            o_alu_zero_condition;
    logic            o_ex_valid;
    logic            o_ex_reg_wr_en;
    logic            o_ex_mem_wr_en;
    logic            o_ex_mem_rd_en;
    logic [4:0]      o_ex_rd_addr;
    logic [XLEN-1:0] o_ex_pc;
    logic [XLEN-1:0] o_ex_store_data;
    logic [1:0]      o_fwd_a;
    logic [1:0]      o_fwd_b;

    modport master (
        output i_stall, i_flush, i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_alu_ctrl, i_id_zero_condition,
               i_id_src_a_sel, i_id_src_b_sel, i_id_reg_wr_en, i_id_mem_wr_en, i_id_mem_rd_en,
               i_mem_rd_addr, i_mem_reg_wr_en, i_mem_fwd_data, i_wb_rd_addr, i_wb_reg_wr_en, i_wb_data,
        input  o_alu_a, o_alu_b, o_alu_ctrl, o_alu_zero_condition, o_ex_valid, o_ex_reg_wr_en,
               o_ex_mem_wr_en, o_ex_mem_rd_en, o_ex_rd_addr, o_ex_pc, o_ex_store_data, o_fwd_a, o_fwd_b
    );

    modport slave (
        input  i_stall, i_flush, i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_alu_ctrl, i_id_zero_condition,
               i_id_src_a_sel, i_id_src_b_sel, i_id_reg_wr_en, i_id_mem_wr_en, i_id_mem_rd_en,
               i_mem_rd_addr, i_mem_reg_wr_en, i_mem_fwd_data, i_wb_rd_addr, i_wb_reg_wr_en, i_wb_data,
        output o_alu_a, o_alu_b, o_alu_ctrl, o_alu_zero_condition, o_ex_valid, o_ex_reg_wr_en,
               o_ex_mem_wr_en, o_ex_mem_rd_en, o_ex_rd_addr, o_ex_pc, o_ex_store_data, o_fwd_a, o_fwd_b
    );

endinterface

// File: rtl/riscv_idex_operand_fwd_mux.sv
// riscv_fwd_mux: per-operand forwarding select between register file, MEM and WB data.
// Forwarding exists only when RISCV_FWD_EN is defined; otherwise the register data passes through.
module riscv_fwd_mux
    import riscv_idex_operand_pkg::*;
(
    input  logic [4:0]      i_rs_addr,
    input  logic [XLEN-1:0] i_reg_data,
    input  logic [4:0]      i_mem_rd_addr,
    input  logic            i_mem_reg_wr_en,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic [4:0]      i_wb_rd_addr,
    input  logic            i_wb_reg_wr_en,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_data,
    output logic [1:0]      o_sel
);

`ifdef RISCV_FWD_EN
    // MEM holds the younger result, so it is checked first; x0 is never a real producer.
    always_comb begin
        o_sel  = FWD_SEL_REG;
        o_data = i_reg_data;
        if (i_mem_reg_wr_en && (i_mem_rd_addr != 5'd0) && (i_mem_rd_addr == i_rs_addr)) begin
            o_sel  = FWD_SEL_MEM;
            o_data = i_mem_data;
        end else if (i_wb_reg_wr_en && (i_wb_rd_addr != 5'd0) && (i_wb_rd_addr == i_rs_addr)) begin
            o_sel  = FWD_SEL_WB;
            o_data = i_wb_data;
        end
    end
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{i_rs_addr, i_mem_rd_addr, i_mem_reg_wr_en, i_mem_data,
                            i_wb_rd_addr, i_wb_reg_wr_en, i_wb_data};
    assign o_sel  = FWD_SEL_REG;
    assign o_data = i_reg_data;
`endif

endmodule

// File: rtl/riscv_idex_operand.sv
// ID/EX pipeline register with EX-stage operand selection and RAW forwarding.
// Forwarding from MEM/WB is enabled by defining RISCV_FWD_EN.
module riscv_idex_operand
    import riscv_idex_operand_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rstn,
    riscv_idex_operand_if.slave  bus
);

    idex_reg_t       r_ex;
    idex_reg_t       w_id;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;

    always_comb begin
        w_id                = EX_BUBBLE;
        w_id.valid          = bus.i_id_valid;
        w_id.pc             = bus.i_id_pc;
        w_id.rs1_data       = bus.i_id_rs1_data;
        w_id.rs2_data       = bus.i_id_rs2_data;
        w_id.imm            = bus.i_id_imm;
        w_id.rs1_addr       = bus.i_id_rs1_addr;
        w_id.rs2_addr       = bus.i_id_rs2_addr;
        w_id.rd_addr        = bus.i_id_rd_addr;
        w_id.alu_ctrl       = bus.i_id_alu_ctrl;
        w_id.zero_condition = bus.i_id_zero_condition;
        w_id.src_a_sel      = bus.i_id_src_a_sel;
        w_id.src_b_sel      = bus.i_id_src_b_sel;
        w_id.reg_wr_en      = bus.i_id_reg_wr_en;
        w_id.mem_wr_en      = bus.i_id_mem_wr_en;
        w_id.mem_rd_en      = bus.i_id_mem_rd_en;
    end

    // Flush outranks stall so the hazard unit can kill a held instruction.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ex <= EX_BUBBLE;
        end else if (bus.i_flush) begin
            r_ex <= EX_BUBBLE;
        end else if (!bus.i_stall) begin
            r_ex <= w_id;
        end
    end

    riscv_fwd_mux u_fwd_rs1 (
        .i_rs_addr       (r_ex.rs1_addr),
        .i_reg_data      (r_ex.rs1_data),
        .i_mem_rd_addr   (bus.i_mem_rd_addr),
        .i_mem_reg_wr_en (bus.i_mem_reg_wr_en),
        .i_mem_data      (bus.i_mem_fwd_data),
        .i_wb_rd_addr    (bus.i_wb_rd_addr),
        .i_wb_reg_wr_en  (bus.i_wb_reg_wr_en),
        .i_wb_data       (bus.i_wb_data),
        .o_data          (w_rs1_fwd),
        .o_sel           (bus.o_fwd_a)
    );

    riscv_fwd_mux u_fwd_rs2 (
        .i_rs_addr       (r_ex.rs2_addr),
        .i_reg_data      (r_ex.rs2_data),
        .i_mem_rd_addr   (bus.i_mem_rd_addr),
        .i_mem_reg_wr_en (bus.i_mem_reg_wr_en),
        .i_mem_data      (bus.i_mem_fwd_data),
        .i_wb_rd_addr    (bus.i_wb_rd_addr),
        .i_wb_reg_wr_en  (bus.i_wb_reg_wr_en),
        .i_wb_data       (bus.i_wb_data),
        .o_data          (w_rs2_fwd),
        .o_sel           (bus.o_fwd_b)
    );

    // Store data always takes forwarded rs2, even when operand B is the immediate.
    assign bus.o_alu_a              = r_ex.src_a_sel ? r_ex.pc  : w_rs1_fwd;
    assign bus.o_alu_b              = r_ex.src_b_sel ? r_ex.imm : w_rs2_fwd;
    assign bus.o_ex_store_data      = w_rs2_fwd;
    assign bus.o_alu_ctrl           = r_ex.alu_ctrl;
    assign bus.o_alu_zero_condition = r_ex.zero_condition;
    assign bus.o_ex_valid           = r_ex.valid;
    assign bus.o_ex_reg_wr_en       = r_ex.reg_wr_en;
    assign bus.o_ex_mem_wr_en       = r_ex.mem_wr_en;
    assign bus.o_ex_mem_rd_en       = r_ex.mem_rd_en;
    assign bus.o_ex_rd_addr         = r_ex.rd_addr;
    assign bus.o_ex_pc              = r_ex.pc;

endmodule
